// File: rtl/cla_carry_unit.sv
// Lookahead carry unit (74182-style) with one registered output stage.
// Consumes per-slice generate/propagate pairs for one row of ALU slices per
// beat and returns the carry into each slice, the row carry-out and the row
// group G/P. Multi-beat words chain their carry through a register.
module cla_carry_unit #(
    parameter int unsigned SLICES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              cin,
    input  logic [SLICES-1:0] g,
    input  logic [SLICES-1:0] p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SLICES-1:0] out_c,
    output logic              out_cout,
    output logic              out_gg,
    output logic              out_pg,
    output logic              out_last,
    output logic              err
);

    typedef enum logic {
        IDLE,
        IN_WORD
    } state_t;

    state_t state, state_nxt;

    logic              carry_q;
    logic              accept;
    logic              proto_err;
    logic [SLICES:0]   chain;
    logic              grp_g;
    logic              grp_p;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a first beat in IN_WORD abandons the old word and restarts
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = in_last ? IDLE : IN_WORD;
        end
    end

    // Carry chain, group G/P and protocol-error detection for the offered beat
    always_comb begin
        chain     = '0;
        grp_g     = 1'b0;
        grp_p     = 1'b1;
        proto_err = 1'b0;
        chain[0]  = (in_first || state == IDLE) ? cin : carry_q;
        for (int unsigned i = 0; i < SLICES; i++) begin
            chain[i+1] = g[i] | (p[i] & chain[i]);
            // group generate is the same ripple evaluated with a zero carry-in
            grp_g      = g[i] | (p[i] & grp_g);
            grp_p      = grp_p & p[i];
        end
        if (accept) begin
            proto_err = (state == IDLE) ? !in_first : in_first;
        end
    end

    // Output stage and inter-beat carry register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_cout  <= 1'b0;
            out_gg    <= 1'b0;
            out_pg    <= 1'b0;
            out_last  <= 1'b0;
            carry_q   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_c     <= chain[SLICES-1:0];
            out_cout  <= chain[SLICES];
            out_gg    <= grp_g;
            out_pg    <= grp_p;
            out_last  <= in_last;
            carry_q   <= chain[SLICES];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky protocol error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (proto_err) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cla_carry_unit.sv
// Directed table-driven bench for cla_carry_unit with SLICES=4, plus
// hand-written sequences for backpressure, protocol errors and mid-word reset.
module tb_cla_carry_unit;

    localparam int unsigned SLICES = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic              in_last;
    logic              cin;
    logic [SLICES-1:0] g;
    logic [SLICES-1:0] p;
    logic              out_valid;
    logic              out_ready;
    logic [SLICES-1:0] out_c;
    logic              out_cout;
    logic              out_gg;
    logic              out_pg;
    logic              out_last;
    logic              err;

    int n_checks;
    int n_fail;

    cla_carry_unit #(.SLICES(SLICES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .cin       (cin),
        .g         (g),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_cout  (out_cout),
        .out_gg    (out_gg),
        .out_pg    (out_pg),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       first;
        logic       last;
        logic       cin;
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       cout;
        logic       gg;
        logic       pg;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one beat at the falling edge, release it after the rising edge
    task automatic send(input logic f, input logic l, input logic ci,
                        input logic [3:0] gv, input logic [3:0] pv);
        @(negedge clk);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        cin      = ci;
        g        = gv;
        p        = pv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        cin       = 1'b0;
        g         = '0;
        p         = '0;
        out_ready = 1'b1;

        //            first last cin  g        p        c        cout gg   pg
        vecs[0] = '{1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 4'b0010, 4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0011, 4'b0111, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 4'b0100, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0011, 1'b0, 1'b0, 1'b0};

        #12;
        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_c",     32'(out_c),     32'd0);
        check("rst_out_cout",  32'(out_cout),  32'd0);
        check("rst_out_gg",    32'(out_gg),    32'd0);
        check("rst_out_pg",    32'(out_pg),    32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Table of beats, drained immediately
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].first, vecs[i].last, vecs[i].cin, vecs[i].g, vecs[i].p);
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_c", i),     32'(out_c),     32'(vecs[i].c));
            check($sformatf("v%0d_cout", i),  32'(out_cout),  32'(vecs[i].cout));
            check($sformatf("v%0d_gg", i),    32'(out_gg),    32'(vecs[i].gg));
            check($sformatf("v%0d_pg", i),    32'(out_pg),    32'(vecs[i].pg));
            check($sformatf("v%0d_last", i),  32'(out_last),  32'(vecs[i].last));
            check($sformatf("v%0d_err", i),   32'(err),       32'd0);
        end
        @(posedge clk);
        #1;
        check("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: result held while a different beat is offered
        out_ready = 1'b0;
        send(1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111);
        check("bp_first_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        in_first = 1'b1;
        in_last  = 1'b1;
        cin      = 1'b0;
        g        = 4'b0001;
        p        = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready),  32'd0);
            check($sformatf("bp%0d_valid", k),    32'(out_valid), 32'd1);
            check($sformatf("bp%0d_c", k),        32'(out_c),     32'hF);
            check($sformatf("bp%0d_cout", k),     32'(out_cout),  32'd1);
            check($sformatf("bp%0d_pg", k),       32'(out_pg),    32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_c",     32'(out_c),     32'h2);
        check("bp_next_pg",    32'(out_pg),    32'd0);
        @(posedge clk);
        #1;
        check("bp_drop_valid", 32'(out_valid), 32'd0);

        // Non-first beat straight after reset: uses cin and raises err
        do_reset();
        send(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
        check("err_idle_c",   32'(out_c), 32'h1);
        check("err_idle_err", 32'(err),   32'd1);
        do_reset();
        check("err_cleared",  32'(err),   32'd0);

        // First beat inside a word: old carry abandoned, cin used, err raised
        send(1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000);
        check("err_word_b1_cout", 32'(out_cout), 32'd1);
        check("err_word_b1_err",  32'(err),      32'd0);
        send(1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111);
        check("err_word_c",    32'(out_c),    32'h0);
        check("err_word_cout", 32'(out_cout), 32'd0);
        check("err_word_err",  32'(err),      32'd1);

        // Reset asserted mid-word while a result is held
        do_reset();
        out_ready = 1'b0;
        send(1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000);
        check("mid_valid_before", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_valid_async", 32'(out_valid),   32'd0);
        check("mid_carry_clr",   32'(dut.carry_q), 32'd0);
        check("mid_c_clr",       32'(out_c),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
        check("mid_after_c",    32'(out_c),    32'h1);
        check("mid_after_cout", 32'(out_cout), 32'd0);
        check("mid_after_err",  32'(err),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cla_carry_unit.md
Name: cla_carry_unit

Overview:
- Lookahead carry unit that consumes group generate/propagate pairs from a row of 4-bit ALU slices and returns the carry into each slice, plus the group carry-out and group G/P.
- Equivalent to a 74182 lookahead generator with one registered output stage and valid/ready handshakes.
- Words wider than one row are processed as a sequence of beats; the carry is held in a register between beats.

Parameters:
- SLICES, 4: G/P pairs per beat, i.e. ALU slices per row; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  beat offered
- in_ready  output  1  unit can accept a beat
- in_first  input  1  beat is the first (least significant) of a word
- in_last  input  1  beat is the last (most significant) of a word
- cin  input  1  word carry-in; used only on a first beat
- g  input  SLICES  per-slice generate, bit 0 = least significant slice
- p  input  SLICES  per-slice propagate
- out_valid  output  1  result beat held
- out_ready  input  1  downstream accepts result
- out_c  output  SLICES  carry into each slice; bit 0 = beat carry-in
- out_cout  output  1  carry out of the most significant slice
- out_gg  output  1  group generate of the beat
- out_pg  output  1  group propagate of the beat
- out_last  output  1  copy of in_last for this beat
- err  output  1  sticky protocol error flag

Behaviour:
- Reset values (asynchronous): out_valid=0, out_c=0, out_cout=0, out_gg=0, out_pg=0, out_last=0, err=0, carry register=0, state=IDLE.
- Accept: a beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, so a full output stage that is being drained can accept in the same cycle.
- Latency: exactly 1 cycle from acceptance to out_valid=1 with the result. Throughput is 1 beat per cycle with no bubbles.
- Carry into the beat, c0: cin if in_first=1 or state=IDLE; otherwise the carry register.
- Carry chain: c(i+1) = g[i] | (p[i] & c(i)) for i = 0..SLICES-1. out_c[i] = c(i); out_cout = c(SLICES).
- Group G/P: out_pg = AND of all p. out_gg = OR over i of (g[i] AND p[j] for all j>i), independent of c0.
- Output hold: while out_valid=1 and out_ready=0, all outputs hold stable. When out_valid=1, out_ready=1 and no new accept, out_valid drops to 0 next cycle.
- Carry register: loaded with c(SLICES) on every accepted beat. It is not cleared on in_last; the next word uses cin.
- State machine:
  - IDLE -> IN_WORD on an accepted beat with in_last=0.
  - IN_WORD -> IDLE on an accepted beat with in_last=1.
  - IN_WORD -> IN_WORD on other accepted beats.
  - A beat with in_first=1 and in_last=1 is a one-beat word and leaves the state at IDLE.
- Protocol errors set err=1, which stays set until reset:
  - accepted beat in IDLE with in_first=0: the beat is still processed as a first beat, using cin.
  - accepted beat in IN_WORD with in_first=1: the old word is abandoned and the beat is processed as a new first beat.
- Inputs other than in_valid are don't-care when in_valid=0. No combinational path from the g/p inputs to the outputs.
- Reset mid-word: state returns to IDLE and any held output is discarded. The next beat must carry in_first, otherwise err is set.

Test Plan:
- SLICES=4, one-beat word, g=0000, p=1111, cin=1 -> next cycle out_c=1111, out_cout=1, out_gg=0, out_pg=1, out_last=1.
- g=0001, p=0000, cin=0, first/last -> out_c=0010, out_cout=0, out_gg=0, out_pg=0; with g=1000 instead -> out_cout=1, out_gg=1.
- Two-beat word: beat 1 first, g=1000, p=0000, cin=0 -> out_cout=1. Beat 2 last, g=0000, p=1111 -> out_c=1111, out_cout=1; following word with cin=0, g=0, p=1111 -> out_c=0000.
- Backpressure: hold out_ready=0 after a result -> in_ready=0 and outputs stable for 5 cycles. Raise out_ready together with in_valid -> old result consumed and new result valid next cycle, no bubble.
- Errors: beat with in_first=0 straight after reset -> result uses cin and err=1. Reset -> err=0. In IN_WORD, a beat with in_first=1 -> err=1 and the beat uses cin.
- Reset asserted mid-word while out_valid=1 -> out_valid=0 immediately (asynchronous) and carry register=0. After release, a first beat with cin=1, g=0, p=0 -> out_c=0001.
